// File: rtl/rv32i_core.sv
// Two-stage (fetch / execute) RV32I integer core with single-cycle instruction and data ports.
// Optional feature macro: RV_CORE_BRANCH_EN enables BRANCH/JAL/JALR and the one-bubble redirect.
module rv32i_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] mem_read_data,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_addr,
  output logic [31:0] pc,
  output logic        instr_rd_en,
  output logic        mem_data_rd_en,
  output logic        mem_data_wr_en
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_REG   = 7'b0110011;
`ifdef RV_CORE_BRANCH_EN
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
`endif

  logic        [31:0] r_pc_p0;
  logic               r_vld_p0;
  logic        [31:0] r_ir_p1;
  logic        [31:0] r_ir_pc_p1;
  logic        [31:0] r_regs [32];

  logic        [6:0]  w_opcode;
  logic        [4:0]  w_rd;
  logic        [4:0]  w_rs1;
  logic        [4:0]  w_rs2;
  logic        [2:0]  w_f3;
  logic        [6:0]  w_f7;
  logic        [4:0]  w_shamt;
  logic        [31:0] w_rs1_val;
  logic        [31:0] w_rs2_val;
  logic signed [31:0] w_rs1_s;
  logic signed [31:0] w_rs2_s;
  logic        [31:0] w_imm_i;
  logic signed [31:0] w_imm_i_s;
  logic        [31:0] w_imm_s;
  logic        [31:0] w_imm_u;
  logic        [31:0] w_ea_ld;
  logic        [31:0] w_ea_st;

  logic               w_we;
  logic        [31:0] w_result;
  logic               w_ld;
  logic               w_st;
  logic        [31:0] w_addr;
  logic        [31:0] w_wdata;
`ifdef RV_CORE_BRANCH_EN
  logic        [31:0] w_imm_b;
  logic        [31:0] w_imm_j;
  logic               w_taken;
  logic        [31:0] w_target;
`endif

  // Little-endian lane pick and extension of the returned load word.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (f3)
      3'd0:    load_extract = {{24{b[7]}}, b};
      3'd1:    load_extract = {{16{h[15]}}, h};
      3'd2:    load_extract = word;
      3'd4:    load_extract = {24'd0, b};
      3'd5:    load_extract = {16'd0, h};
      default: load_extract = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] store_replicate(input logic [31:0] data, input logic [2:0] f3);
    case (f3)
      3'd0:    store_replicate = {4{data[7:0]}};
      3'd1:    store_replicate = {2{data[15:0]}};
      default: store_replicate = data;
    endcase
  endfunction

  assign w_opcode  = r_ir_p1[6:0];
  assign w_rd      = r_ir_p1[11:7];
  assign w_f3      = r_ir_p1[14:12];
  assign w_rs1     = r_ir_p1[19:15];
  assign w_rs2     = r_ir_p1[24:20];
  assign w_f7      = r_ir_p1[31:25];
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
  assign w_rs1_s   = w_rs1_val;
  assign w_rs2_s   = w_rs2_val;
  assign w_imm_i   = {{20{r_ir_p1[31]}}, r_ir_p1[31:20]};
  assign w_imm_i_s = w_imm_i;
  assign w_imm_s   = {{20{r_ir_p1[31]}}, r_ir_p1[31:25], r_ir_p1[11:7]};
  assign w_imm_u   = {r_ir_p1[31:12], 12'd0};
  assign w_shamt   = (w_opcode == OP_REG) ? w_rs2_val[4:0] : r_ir_p1[24:20];
  assign w_ea_ld   = w_rs1_val + w_imm_i;
  assign w_ea_st   = w_rs1_val + w_imm_s;
`ifdef RV_CORE_BRANCH_EN
  assign w_imm_b   = {{20{r_ir_p1[31]}}, r_ir_p1[7], r_ir_p1[30:25], r_ir_p1[11:8], 1'b0};
  assign w_imm_j   = {{12{r_ir_p1[31]}}, r_ir_p1[19:12], r_ir_p1[20], r_ir_p1[30:21], 1'b0};
`endif

  // Execute stage (p1): combinational decode of IR against the register file.
  always_comb begin
    w_we     = 1'b0;
    w_result = 32'd0;
    w_ld     = 1'b0;
    w_st     = 1'b0;
    w_addr   = 32'd0;
    w_wdata  = 32'd0;
`ifdef RV_CORE_BRANCH_EN
    w_taken  = 1'b0;
    w_target = 32'd0;
`endif
    case (w_opcode)
      OP_LUI: begin
        w_we     = 1'b1;
        w_result = w_imm_u;
      end
      OP_AUIPC: begin
        w_we     = 1'b1;
        w_result = r_ir_pc_p1 + w_imm_u;
      end
      OP_IMM: begin
        case (w_f3)
          3'd0: begin w_we = 1'b1; w_result = w_rs1_val + w_imm_i; end
          3'd2: begin w_we = 1'b1; w_result = {31'd0, w_rs1_s < w_imm_i_s}; end
          3'd3: begin w_we = 1'b1; w_result = {31'd0, w_rs1_val < w_imm_i}; end
          3'd4: begin w_we = 1'b1; w_result = w_rs1_val ^ w_imm_i; end
          3'd6: begin w_we = 1'b1; w_result = w_rs1_val | w_imm_i; end
          3'd7: begin w_we = 1'b1; w_result = w_rs1_val & w_imm_i; end
          3'd1: if (w_f7 == 7'h00) begin w_we = 1'b1; w_result = w_rs1_val << w_shamt; end
          default: begin
            if (w_f7 == 7'h00) begin
              w_we = 1'b1; w_result = w_rs1_val >> w_shamt;
            end else if (w_f7 == 7'h20) begin
              w_we = 1'b1; w_result = 32'(w_rs1_s >>> w_shamt);
            end
          end
        endcase
      end
      OP_REG: begin
        if (w_f7 == 7'h00) begin
          w_we = 1'b1;
          case (w_f3)
            3'd0:    w_result = w_rs1_val + w_rs2_val;
            3'd1:    w_result = w_rs1_val << w_shamt;
            3'd2:    w_result = {31'd0, w_rs1_s < w_rs2_s};
            3'd3:    w_result = {31'd0, w_rs1_val < w_rs2_val};
            3'd4:    w_result = w_rs1_val ^ w_rs2_val;
            3'd5:    w_result = w_rs1_val >> w_shamt;
            3'd6:    w_result = w_rs1_val | w_rs2_val;
            default: w_result = w_rs1_val & w_rs2_val;
          endcase
        end else if (w_f7 == 7'h20 && w_f3 == 3'd0) begin
          w_we = 1'b1; w_result = w_rs1_val - w_rs2_val;
        end else if (w_f7 == 7'h20 && w_f3 == 3'd5) begin
          w_we = 1'b1; w_result = 32'(w_rs1_s >>> w_shamt);
        end
      end
      OP_LOAD: begin
        if (w_f3 != 3'd3 && w_f3 != 3'd6 && w_f3 != 3'd7) begin
          w_ld     = 1'b1;
          w_addr   = w_ea_ld;
          w_we     = 1'b1;
          w_result = load_extract(mem_read_data, w_ea_ld[1:0], w_f3);
        end
      end
      OP_STORE: begin
        if (w_f3 <= 3'd2) begin
          w_st    = 1'b1;
          w_addr  = w_ea_st;
          w_wdata = store_replicate(w_rs2_val, w_f3);
        end
      end
`ifdef RV_CORE_BRANCH_EN
      OP_JAL: begin
        w_we     = 1'b1;
        w_result = r_ir_pc_p1 + 32'd4;
        w_taken  = 1'b1;
        w_target = r_ir_pc_p1 + w_imm_j;
      end
      OP_JALR: begin
        if (w_f3 == 3'd0) begin
          w_we     = 1'b1;
          w_result = r_ir_pc_p1 + 32'd4;
          w_taken  = 1'b1;
          w_target = w_ea_ld & ~32'd1;
        end
      end
      OP_BR: begin
        w_target = r_ir_pc_p1 + w_imm_b;
        case (w_f3)
          3'd0:    w_taken = (w_rs1_val == w_rs2_val);
          3'd1:    w_taken = (w_rs1_val != w_rs2_val);
          3'd4:    w_taken = (w_rs1_s < w_rs2_s);
          3'd5:    w_taken = (w_rs1_s >= w_rs2_s);
          3'd6:    w_taken = (w_rs1_val < w_rs2_val);
          3'd7:    w_taken = (w_rs1_val >= w_rs2_val);
          default: w_taken = 1'b0;
        endcase
      end
`endif
      default: ;
    endcase
  end

  // Reset gates the bus so an access in flight during the reset cycle never reaches memory.
  assign mem_data_rd_en = w_ld & ~rst_n;
  assign mem_data_wr_en = w_st & ~rst_n;
  assign mem_addr       = rst_n ? 32'd0 : w_addr;
  assign mem_write_data = rst_n ? 32'd0 : w_wdata;
  assign pc             = r_pc_p0;
  assign instr_rd_en    = r_vld_p0;

  // Fetch stage (p0 -> p1) and writeback of the execute result.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_vld_p0   <= 1'b0;
      r_pc_p0    <= 32'd0;
      r_ir_p1    <= NOP;
      r_ir_pc_p1 <= 32'd0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
      r_vld_p0 <= 1'b1;
      if (w_we && w_rd != 5'd0) r_regs[w_rd] <= w_result;
`ifdef RV_CORE_BRANCH_EN
      if (w_taken) begin
        r_pc_p0    <= w_target;
        r_ir_p1    <= NOP;
        r_ir_pc_p1 <= r_pc_p0;
      end else if (r_vld_p0) begin
`else
      if (r_vld_p0) begin
`endif
        r_ir_p1    <= instr;
        r_ir_pc_p1 <= r_pc_p0;
        r_pc_p0    <= r_pc_p0 + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_core.sv
// Directed self-checking bench for rv32i_core; instruction memory is a small program array.
module tb_rv32i_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = 32'h0000_0013;
  logic [31:0] mem_read_data = 32'd0;
  logic [31:0] mem_write_data;
  logic [31:0] mem_addr;
  logic [31:0] pc;
  logic        instr_rd_en;
  logic        mem_data_rd_en;
  logic        mem_data_wr_en;

  logic [31:0] prog [64];
  int n_pass = 0;
  int n_total = 0;

  rv32i_core dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_read_data(mem_read_data),
    .mem_write_data(mem_write_data), .mem_addr(mem_addr), .pc(pc),
    .instr_rd_en(instr_rd_en), .mem_data_rd_en(mem_data_rd_en), .mem_data_wr_en(mem_data_wr_en)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] e_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                      logic [4:0] rd);
    return {imm[11:0], rs1, f3, rd, 7'h13};
  endfunction
  function automatic logic [31:0] e_ld(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                       logic [4:0] rd);
    return {imm[11:0], rs1, f3, rd, 7'h03};
  endfunction
  function automatic logic [31:0] e_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] e_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_j(logic [31:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] e_u(logic [31:0] imm20, logic [4:0] rd, logic [6:0] op);
    return {imm20[19:0], rd, op};
  endfunction

  // Advance one clock; outputs are sampled 1ns after the edge, then the next instruction is presented.
  task automatic tick();
    @(posedge clk);
    #1;
    instr = prog[pc[7:2]];
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0013;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_prog();
    rst_n = 1'b1;
    repeat (3) tick();
    n_total++; if (pc !== 32'd0) $display("FAIL rst_pc got %h want 0", pc); else n_pass++;
    n_total++; if (instr_rd_en !== 1'b0) $display("FAIL rst_fetch got %b want 0", instr_rd_en); else n_pass++;
    n_total++; if ({mem_data_rd_en, mem_data_wr_en} !== 2'b00)
      $display("FAIL rst_strobes got %b want 00", {mem_data_rd_en, mem_data_wr_en}); else n_pass++;
    n_total++; if ({mem_addr, mem_write_data} !== 64'd0)
      $display("FAIL rst_bus got %h/%h want 0/0", mem_addr, mem_write_data); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_total++; if (instr_rd_en !== 1'b1) $display("FAIL rel_fetch got %b want 1", instr_rd_en); else n_pass++;
    n_total++; if (pc !== 32'd0) $display("FAIL rel_pc0 got %h want 0", pc); else n_pass++;
    tick();
    n_total++; if (pc !== 32'd4) $display("FAIL rel_pc4 got %h want 4", pc); else n_pass++;
    tick();
    n_total++; if (pc !== 32'd8) $display("FAIL rel_pc8 got %h want 8", pc); else n_pass++;
  endtask

  task automatic test_sb_uart();
    clear_prog();
    prog[0] = e_i(32'h14, 5'd0, 3'd0, 5'd3);
    prog[1] = e_i(32'd5, 5'd0, 3'd0, 5'd4);
    prog[2] = e_r(7'h00, 5'd3, 5'd4, 3'd1, 5'd5);
    prog[3] = e_i(32'h48, 5'd0, 3'd0, 5'd2);
    prog[4] = e_s(32'd0, 5'd2, 5'd5, 3'd0);
    do_reset();
    repeat (4) tick();
    n_total++; if (mem_data_wr_en !== 1'b0 || mem_addr !== 32'd0)
      $display("FAIL sb_idle got we=%b addr=%h want 0/0", mem_data_wr_en, mem_addr); else n_pass++;
    tick();
    n_total++; if (mem_data_wr_en !== 1'b1) $display("FAIL sb_we got %b want 1", mem_data_wr_en); else n_pass++;
    n_total++; if (mem_addr !== 32'h0050_0000) $display("FAIL sb_addr got %h want 00500000", mem_addr); else n_pass++;
    n_total++; if (mem_write_data !== 32'h4848_4848)
      $display("FAIL sb_data got %h want 48484848", mem_write_data); else n_pass++;
    n_total++; if (mem_data_rd_en !== 1'b0) $display("FAIL sb_rd got %b want 0", mem_data_rd_en); else n_pass++;
  endtask

  task automatic test_loads();
    logic [31:0] exp_d [6];
    exp_d = '{32'hFFFF_FF80, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_0012, 32'h80FF_1234, 32'h80FF_80FF};
    clear_prog();
    mem_read_data = 32'h80FF_1234;
    prog[0] = e_ld(32'd3, 5'd0, 3'd0, 5'd6);
    prog[1] = e_ld(32'd2, 5'd0, 3'd1, 5'd7);
    prog[2] = e_ld(32'd2, 5'd0, 3'd5, 5'd8);
    prog[3] = e_ld(32'd1, 5'd0, 3'd4, 5'd9);
    prog[4] = e_ld(32'd0, 5'd0, 3'd2, 5'd10);
    for (int i = 0; i < 5; i++) prog[5 + i] = e_s(32'(4 * i), 5'(6 + i), 5'd0, 3'd2);
    prog[10] = e_s(32'd20, 5'd7, 5'd0, 3'd1);
    do_reset();
    tick();
    n_total++; if (mem_data_rd_en !== 1'b1) $display("FAIL lb_rd got %b want 1", mem_data_rd_en); else n_pass++;
    n_total++; if (mem_addr !== 32'd3) $display("FAIL lb_addr got %h want 3", mem_addr); else n_pass++;
    n_total++; if (mem_data_wr_en !== 1'b0) $display("FAIL lb_we got %b want 0", mem_data_wr_en); else n_pass++;
    repeat (4) tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++;
      if (mem_data_wr_en !== 1'b1 || mem_data_rd_en !== 1'b0 || mem_addr !== 32'(4 * i) ||
          mem_write_data !== exp_d[i])
        $display("FAIL ld_st%0d got we=%b rd=%b addr=%h data=%h want 1/0/%h/%h", i, mem_data_wr_en,
                 mem_data_rd_en, mem_addr, mem_write_data, 32'(4 * i), exp_d[i]);
      else n_pass++;
    end
    mem_read_data = 32'd0;
  endtask

  task automatic test_x0();
    clear_prog();
    prog[0] = e_i(32'd5, 5'd0, 3'd0, 5'd0);
    prog[1] = e_s(32'd8, 5'd0, 5'd0, 3'd2);
    do_reset();
    tick();
    n_total++; if (mem_data_wr_en !== 1'b0) $display("FAIL x0_addi_we got %b want 0", mem_data_wr_en); else n_pass++;
    tick();
    n_total++; if (mem_data_wr_en !== 1'b1 || mem_addr !== 32'd8 || mem_write_data !== 32'd0)
      $display("FAIL x0_sw got we=%b addr=%h data=%h want 1/8/0", mem_data_wr_en, mem_addr, mem_write_data);
    else n_pass++;
  endtask

  task automatic test_alu();
    logic [31:0] exp_d [9];
    logic [4:0]  regs_d [9];
    exp_d  = '{32'd4, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h1FFF_FFFF, 32'h1234_5000, 32'hEDCB_AFFF,
               32'h0000_1024, 32'h8000_0000};
    regs_d = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
    clear_prog();
    prog[0]  = e_i(32'hFFFF_FFFF, 5'd0, 3'd0, 5'd1);
    prog[1]  = e_i(32'd3, 5'd0, 3'd0, 5'd2);
    prog[2]  = e_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd3);
    prog[3]  = e_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd4);
    prog[4]  = e_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd5);
    prog[5]  = e_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd6);
    prog[6]  = e_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd7);
    prog[7]  = e_u(32'h12345, 5'd8, 7'h37);
    prog[8]  = e_i(32'hFFFF_FFFF, 5'd8, 3'd4, 5'd9);
    prog[9]  = e_u(32'd1, 5'd10, 7'h17);
    prog[10] = e_i(32'd31, 5'd2, 3'd1, 5'd11);
    prog[11] = e_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3);
    for (int i = 0; i < 9; i++) prog[12 + i] = e_s(32'd0, regs_d[i], 5'd0, 3'd2);
    do_reset();
    repeat (12) tick();
    n_total++; if (mem_data_wr_en !== 1'b0) $display("FAIL bad_f7_we got %b want 0", mem_data_wr_en); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_total++;
      if (mem_data_wr_en !== 1'b1 || mem_write_data !== exp_d[i])
        $display("FAIL alu_x%0d got we=%b data=%h want 1/%h", regs_d[i], mem_data_wr_en, mem_write_data,
                 exp_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    clear_prog();
    prog[0]  = e_b(32'd8, 5'd0, 5'd0, 3'd1);
    prog[4]  = e_b(32'd16, 5'd0, 5'd0, 3'd0);
    prog[5]  = e_i(32'd7, 5'd0, 3'd0, 5'd5);
    prog[8]  = e_j(32'd8, 5'd1);
    prog[9]  = e_i(32'd9, 5'd0, 3'd0, 5'd5);
    prog[10] = e_s(32'd0, 5'd1, 5'd0, 3'd2);
    prog[11] = e_s(32'd4, 5'd5, 5'd0, 3'd2);
    do_reset();
    repeat (2) tick();
    n_total++; if (pc !== 32'd8) $display("FAIL bne_nt_pc got %h want 8", pc); else n_pass++;
    repeat (3) tick();
    n_total++; if (pc !== 32'h14) $display("FAIL beq_exec_pc got %h want 14", pc); else n_pass++;
    tick();
`ifdef RV_CORE_BRANCH_EN
    n_total++; if (pc !== 32'h20) $display("FAIL beq_tgt_pc got %h want 20", pc); else n_pass++;
    n_total++; if (mem_data_wr_en !== 1'b0) $display("FAIL flush_we got %b want 0", mem_data_wr_en); else n_pass++;
    repeat (2) tick();
    n_total++; if (pc !== 32'h28) $display("FAIL jal_pc got %h want 28", pc); else n_pass++;
    tick();
    n_total++; if (mem_data_wr_en !== 1'b1 || mem_write_data !== 32'h24)
      $display("FAIL jal_link got we=%b data=%h want 1/24", mem_data_wr_en, mem_write_data); else n_pass++;
    tick();
    n_total++; if (mem_addr !== 32'd4 || mem_write_data !== 32'd0)
      $display("FAIL flushed_x5 got addr=%h data=%h want 4/0", mem_addr, mem_write_data); else n_pass++;
`else
    n_total++; if (pc !== 32'h18) $display("FAIL seq_pc got %h want 18", pc); else n_pass++;
    repeat (4) tick();
    n_total++; if (pc !== 32'h28) $display("FAIL seq_pc28 got %h want 28", pc); else n_pass++;
    tick();
    n_total++; if (mem_data_wr_en !== 1'b1 || mem_write_data !== 32'd0)
      $display("FAIL jal_nop got we=%b data=%h want 1/0", mem_data_wr_en, mem_write_data); else n_pass++;
    tick();
    n_total++; if (mem_addr !== 32'd4 || mem_write_data !== 32'd9)
      $display("FAIL seq_x5 got addr=%h data=%h want 4/9", mem_addr, mem_write_data); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    clear_prog();
    prog[0] = e_i(32'h55, 5'd0, 3'd0, 5'd2);
    prog[1] = e_s(32'd0, 5'd2, 5'd0, 3'd2);
    do_reset();
    repeat (2) tick();
    n_total++; if (mem_data_wr_en !== 1'b1 || mem_write_data !== 32'h55)
      $display("FAIL mid_pre got we=%b data=%h want 1/55", mem_data_wr_en, mem_write_data); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (mem_data_wr_en !== 1'b0 || mem_addr !== 32'd0 || mem_write_data !== 32'd0)
      $display("FAIL mid_gate got we=%b addr=%h data=%h want 0/0/0", mem_data_wr_en, mem_addr, mem_write_data);
    else n_pass++;
    tick();
    n_total++; if (pc !== 32'd0 || instr_rd_en !== 1'b0)
      $display("FAIL mid_rst got pc=%h fetch=%b want 0/0", pc, instr_rd_en); else n_pass++;
    rst_n = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sb_uart();
    test_loads();
    test_x0();
    test_alu();
    test_branch();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv32i_core.md
# rv32i_core

Single-issue RV32I integer core with separate instruction and data ports. It drives a program counter, accepts one 32-bit instruction per cycle on `instr`, and executes it in a registered execute stage. Loads and stores go over a simple single-cycle data bus. It sits under the processor-subsystem top, between instruction memory (or flash) and the data memory/peripheral interconnect (RAM, UART at 0x0050_0000).

## Interface
- No parameters.
- `clk` input 1 — core clock; all state updates on the rising edge.
- `rst_n` input 1 — synchronous, active-high reset. The name is kept for codebase consistency; `1` means reset.
- `instr` input 32 — instruction word at address `pc`, valid in the same cycle.
- `mem_read_data` input 32 — word containing `mem_addr`, returned combinationally in the same cycle as `mem_data_rd_en`.
- `mem_write_data` output 32 — store data, lane-replicated.
- `mem_addr` output 32 — byte address of the load or store.
- `pc` output 32 — fetch address of the instruction expected on `instr`.
- `instr_rd_en` output 1 — instruction fetch strobe.
- `mem_data_rd_en` output 1 — load strobe.
- `mem_data_wr_en` output 1 — store strobe.

## Operation
- Two stages: fetch and execute.
- **Fetch:** at each edge with `instr_rd_en=1`, load IR←`instr`, IR_PC←`pc`, and `pc`←`pc`+4.
- **Execute:** decode IR combinationally. Read rs1/rs2 from a 32×32 register file; x0 always reads 0 and writes to it are discarded. The result is written to rd at the end of the execute cycle.
- Supported instructions:
  - LUI, AUIPC
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  - LOAD: LB, LH, LW, LBU, LHU
  - STORE: SB, SH, SW
  - BRANCH, JAL, JALR
- Shift amount is the low 5 bits of the operand. All arithmetic is modulo 2^32.
- FENCE, SYSTEM, and any unknown opcode/funct combination execute as NOP: no register write, no memory strobe.
- **Load/store:**
  - `mem_addr` = rs1 + sext(imm12); no alignment check.
  - Loads pick the lane from `mem_read_data` using `addr[1:0]` (little-endian). LB/LH sign-extend; LBU/LHU zero-extend.
  - SB replicates the byte ×4 and SH replicates the halfword ×2 on `mem_write_data`; SW drives the full word.
- When not executing a load or store: `mem_addr`=0, `mem_write_data`=0, both strobes 0.
- **Branches/jumps:**
  - JAL/JALR write rd=IR_PC+4.
  - JALR target is (rs1+imm)&~1.
  - On a taken branch or jump: `pc`←target at the end of the execute cycle, and the instruction captured at that same edge is replaced by NOP (one bubble).
  - Not-taken branches cost nothing.

## Timing
- Reset values: `pc`=0, IR=NOP (0x0000_0013), IR_PC=0, all registers 0, `instr_rd_en`=0, both strobes 0, `mem_addr`=0, `mem_write_data`=0.
- Reset asserted mid-operation overrides everything at the next edge; any in-flight store or register write in that cycle is suppressed.
- First cycle after reset release: `instr_rd_en`=1, `pc`=0. Afterwards `instr_rd_en` stays 1 every cycle.
- Instruction presented at edge N executes in cycle N→N+1 and writes back at edge N+1.
- Memory strobes, address, and write data are combinational from IR and the register file. They are valid only within the execute cycle; each strobe lasts exactly one cycle per access.
- Back-to-back dependent instructions need no stall: a result written at edge N+1 is read by the instruction executing in the next cycle.
- Taken control transfer costs one extra cycle; `pc` wraps modulo 2^32.

## Configuration
- `RV_CORE_BRANCH_EN` defined: BRANCH, JAL, and JALR execute as described.
- Undefined: those opcodes execute as NOP (no rd write, no redirect), `pc` is strictly sequential, and no flush logic is built.

## Test plan
- Hold `rst_n`=1 for 3 cycles → `pc`=0, `instr_rd_en`=0, strobes 0. After release → `pc` reads 0,4,8,… on successive cycles.
- Sequence `addi x3,x0,0x14`; `addi x4,x0,5`; `sll x5,x4,x3`; `addi x2,x0,0x48`; `sb x2,0(x5)` → in the SB execute cycle `mem_data_wr_en`=1, `mem_addr`=0x0050_0000, `mem_write_data`=0x4848_4848.
- `lb x6,3(x0)` with `mem_read_data`=0x80FF_1234, then `sw x6,0(x0)` → `mem_data_rd_en`=1 and `mem_addr`=3 on the load; store data is 0xFFFF_FF80.
- `addi x0,x0,5`, then `sw x0,8(x0)` → `mem_write_data`=0, `mem_addr`=8.
- With `RV_CORE_BRANCH_EN`: `beq x0,x0,+16` at `pc` 0x10 → `pc`=0x20 after execute, and the instruction fetched from 0x14 causes no write.
- With `RV_CORE_BRANCH_EN`: `jal x1,+8` at 0x20 → x1=0x24 and `pc`=0x28.
